pipeline_ex_exmem: RTL and testbench
====================================

# pipeline_ex_exmem

Execute stage of the five-stage MIPS pipeline, directly upstream of the MEM stage. It computes the ALU result from already-forwarded operands and runs an iterative multiply/divide unit with HI/LO registers. It raises a stall to the hazard unit when an instruction depends on an in-flight multiply/divide. It registers the 73-bit EXMEM bundle consumed by the MEM stage.

## Interface
- DIV0_Q, 32'hFFFF_FFFF, LO value written on divide-by-zero.
- clk  in  1  system clock; all state rises on posedge.
- reset  in  1  asynchronous, active-low; clears all state.
- valid  in  1  IDEX holds a real instruction.
- flush  in  1  kill the EX-stage instruction; a bubble is written to EXMEM.
- op_a, op_b  in  32  forwarded rs/rt (or immediate) operands.
- store_data  in  32  forwarded rt for stores.
- shamt  in  5  shift amount; the decoder muxes rs[4:0] in for variable shifts.
- alu_fun  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 LUI, 12 MFHI, 13 MFLO, 14-15 ADD.
- md_op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none.
- wb_ctrl  in  7  writeback control and destination register, passed through unchanged.
- mem_read, mem_write  in  1  memory controls.
- stall  out  1  freeze PC/IFID/IDEX this cycle.
- md_busy  out  1  multiply/divide in flight.
- EXMEM  out  73  [31:0] ALU result/address, [63:32] store data, [70:64] wb_ctrl, [71] mem_read, [72] mem_write.

## Operation
- ALU is combinational. ADD and SUB wrap modulo 2^32 and raise no overflow trap.
- SLT is signed; SLTU is unsigned. Each yields 0 or 1.
- Shifts shift op_b by shamt. LUI yields {op_b[15:0],16'h0}.
- MFHI and MFLO yield HI and LO respectively.
- stall = valid & ~flush & md_busy & (alu_fun∈{MFHI,MFLO} | md_op∈1..6).
- EXMEM update, in priority order:
  - ~reset: 0.
  - flush, stall, or ~valid: bubble (all 73 bits 0).
  - Otherwise: {mem_write, mem_read, wb_ctrl, store_data, alu_result}.
- MTHI/MTLO (not stalled): HI or LO takes op_a at the clock edge.
- Multiply/divide FSM:
  - IDLE: a valid, unflushed, unstalled md_op 1-4 latches |op_a| and |op_b| (raw values for the unsigned ops) plus the result sign, clears the step counter, and moves to MUL or DIV.
  - MUL: shift-add, one bit per cycle, 32 steps, then FIX.
  - DIV: restoring, one quotient bit per cycle, 32 steps, then FIX.
  - FIX: applies two's-complement sign correction. For DIV, remainder takes the dividend's sign and quotient takes sign(a)^sign(b). Writes HI/LO, then returns to IDLE.
- md_busy = (state ≠ IDLE).
- Divide by zero: LO=DIV0_Q, HI=op_a. No trap.
- 0x8000_0000 / -1 (DIV): LO=0x8000_0000, HI=0.
- The multiply/divide instruction itself flows into EXMEM with its own wb_ctrl. The decoder guarantees RegWrite=0 for it.
- A flush while md_busy does not abort the operation; it was issued architecturally.

## Timing
- Reset values: EXMEM=0, HI=LO=0, FSM=IDLE, md_busy=0, stall=0.
- ALU result appears in EXMEM one edge after issue.
- Multiply/divide issued at edge N: md_busy high from N+1 through N+33. HI/LO are valid after edge N+34.
- A dependent MFHI/MFLO issued at N+1 stalls for 33 cycles. It is captured into EXMEM at edge N+35 with the new value.
- stall is combinational from inputs and state. It has no feedback path through EXMEM.
- Reset asserted mid-operation: FSM→IDLE and HI/LO→0 immediately. The partial result is discarded.
- MTHI and FIX are mutually exclusive: MTHI/MTLO stalls while md_busy.
- Back-to-back multiply/divide: the second stalls until the FSM reaches IDLE, then issues that cycle.

## Configuration
- PIPELINE_MULDIV_EN defined: the multiply/divide FSM and HI/LO are built as above.
- PIPELINE_MULDIV_EN undefined:
  - No FSM or HI/LO registers; md_op is ignored.
  - md_busy=0 and stall=0 constantly.
  - MFHI and MFLO yield 0.

## Test plan
- Reset low mid-DIV at step 10 -> EXMEM=0, md_busy=0, HI=LO=0 on the same cycle; after release, MFLO returns 0.
- ADD 0x7FFF_FFFF + 1 -> EXMEM[31:0]=0x8000_0000 next edge. SLT -1,1 -> 1. SLTU -1,1 -> 0. SRA 0x8000_0000 by 4 -> 0xF800_0000.
- MULT 0xFFFF_FFFE (-2) × 3, then MFLO the next cycle -> stall high 33 cycles, then EXMEM[31:0]=0xFFFF_FFFA. MFHI -> 0xFFFF_FFFF.
- DIV -7 / 2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 7/0 -> LO=DIV0_Q, HI=7.
- sw with flush=1 -> EXMEM all zero, mem_write=0. Same sw unflushed -> EXMEM[72]=1, [63:32]=store_data.
- Build without PIPELINE_MULDIV_EN: MULT then MFLO -> no stall, EXMEM[31:0]=0.

Source files
------------

// File: rtl/pipeline_ex_exmem.sv
// pipeline_ex_exmem: execute stage of the five-stage MIPS pipeline.
//   Computes the ALU result from forwarded operands, runs an iterative
//   multiply/divide unit with HI/LO, raises stall when an instruction depends
//   on an in-flight multiply/divide, and registers the 73-bit EXMEM bundle.
//
// Build option:
//   PIPELINE_MULDIV_EN  defined   -> multiply/divide FSM and HI/LO are built.
//                       undefined -> md_op ignored, md_busy=stall=0, MFHI/MFLO=0.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   valid       IDEX holds a real instruction
//   flush       kill the EX instruction (bubble into EXMEM)
//   op_a, op_b  forwarded operands
//   store_data  forwarded rt for stores
//   shamt       shift amount
//   alu_fun     ALU function select
//   md_op       multiply/divide/MTHI/MTLO select
//   wb_ctrl     writeback control, passed through
//   mem_read, mem_write  memory controls, passed through
//   stall       freeze PC/IFID/IDEX this cycle (combinational)
//   md_busy     multiply/divide in flight
//   EXMEM       {mem_write, mem_read, wb_ctrl, store_data, alu_result}
module pipeline_ex_exmem #(
    parameter logic [31:0] DIV0_Q = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        flush,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] store_data,
    input  logic [4:0]  shamt,
    input  logic [3:0]  alu_fun,
    input  logic [2:0]  md_op,
    input  logic [6:0]  wb_ctrl,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        stall,
    output logic        md_busy,
    output logic [72:0] EXMEM
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned EXMEM_W = 73;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MFHI = 4'd12;
    localparam logic [3:0] ALU_MFLO = 4'd13;

    logic [XLEN-1:0]    alu_result_c;
    logic [XLEN-1:0]    hi_val_c;
    logic [XLEN-1:0]    lo_val_c;
    logic               stall_c;
    logic               md_busy_c;
    logic [EXMEM_W-1:0] exmem_d;
    logic [EXMEM_W-1:0] exmem_q;

`ifdef PIPELINE_MULDIV_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    logic [1:0]        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [63:0]       acc_q, acc_d;     // MUL: product; DIV: {remainder, quotient}
    logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
    logic              div_q, div_d;
    logic              neg_q, neg_d;     // product / quotient sign
    logic              rneg_q, rneg_d;   // remainder sign (dividend sign)
    logic              div0_q, div0_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              md_dep_c;
    logic              md_fire_c;
    logic              md_signed_c;
    logic [XLEN-1:0]   abs_a_c, abs_b_c;
    logic [XLEN:0]     mul_sum_c;
    logic [63:0]       mul_next_c;
    logic [XLEN:0]     div_rs_c;
    logic              div_ge_c;
    logic [XLEN-1:0]   div_diff_c;
    logic [63:0]       div_next_c;
    logic [63:0]       mul_fix_c;
    logic [XLEN-1:0]   quo_fix_c, rem_fix_c;

    // Hazard detect: anything touching HI/LO or the unit waits for it.
    always_comb begin
        md_dep_c  = (alu_fun == ALU_MFHI) || (alu_fun == ALU_MFLO) ||
                    ((md_op >= MD_MULT) && (md_op <= MD_MTLO));
        md_busy_c = (state_q != S_IDLE);
        stall_c   = valid & ~flush & md_busy_c & md_dep_c;
        md_fire_c = valid & ~flush & ~stall_c;
        hi_val_c  = hi_q;
        lo_val_c  = lo_q;
    end

    // Step datapath for shift-add multiply and restoring divide.
    always_comb begin
        md_signed_c = (md_op == MD_MULT) || (md_op == MD_DIV);
        abs_a_c     = op_a[31] ? (~op_a + 32'd1) : op_a;
        abs_b_c     = op_b[31] ? (~op_b + 32'd1) : op_b;

        mul_sum_c   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
        mul_next_c  = {mul_sum_c, acc_q[31:1]};

        // Partial remainder stays below the divisor, so the difference fits 32 bits.
        div_rs_c    = {acc_q[63:32], acc_q[31]};
        div_ge_c    = (div_rs_c >= {1'b0, opb_q});
        div_diff_c  = div_rs_c[31:0] - opb_q;
        div_next_c  = div_ge_c ? {div_diff_c, acc_q[30:0], 1'b1}
                               : {div_rs_c[31:0], acc_q[30:0], 1'b0};

        mul_fix_c   = neg_q  ? (~acc_q + 64'd1) : acc_q;
        quo_fix_c   = neg_q  ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix_c   = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    end

    // Multiply/divide FSM next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (md_fire_c) begin
                    if ((md_op >= MD_MULT) && (md_op <= MD_DIVU)) begin
                        acc_d   = {32'd0, (md_signed_c ? abs_a_c : op_a)};
                        opb_d   = md_signed_c ? abs_b_c : op_b;
                        neg_d   = md_signed_c & (op_a[31] ^ op_b[31]);
                        rneg_d  = md_signed_c & op_a[31];
                        div_d   = (md_op == MD_DIV) || (md_op == MD_DIVU);
                        div0_d  = (op_b == 32'd0);
                        cnt_d   = 5'd0;
                        state_d = ((md_op == MD_DIV) || (md_op == MD_DIVU)) ? S_DIV : S_MUL;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = op_a;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = op_a;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next_c;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = div_next_c;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                // Divide by zero leaves the dividend in the remainder naturally.
                if (div_q) begin
                    lo_d = div0_q ? DIV0_Q : quo_fix_c;
                    hi_d = rem_fix_c;
                end else begin
                    hi_d = mul_fix_c[63:32];
                    lo_d = mul_fix_c[31:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Multiply/divide state; reset discards any partial result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opb_q   <= 32'd0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
`else
    logic unused_md_op;

    // No multiply/divide unit: never busy, HI/LO read as zero.
    always_comb begin
        md_busy_c    = 1'b0;
        stall_c      = 1'b0;
        hi_val_c     = '0;
        lo_val_c     = '0;
        unused_md_op = &{1'b0, md_op};
    end
`endif

    // ALU, wrap-around arithmetic with no overflow trap.
    always_comb begin
        alu_result_c = op_a + op_b;
        case (alu_fun)
            ALU_ADD:  alu_result_c = op_a + op_b;
            ALU_SUB:  alu_result_c = op_a - op_b;
            ALU_AND:  alu_result_c = op_a & op_b;
            ALU_OR:   alu_result_c = op_a | op_b;
            ALU_XOR:  alu_result_c = op_a ^ op_b;
            ALU_NOR:  alu_result_c = ~(op_a | op_b);
            ALU_SLL:  alu_result_c = op_b << shamt;
            ALU_SRL:  alu_result_c = op_b >> shamt;
            ALU_SRA:  alu_result_c = $unsigned($signed(op_b) >>> shamt);
            ALU_SLT:  alu_result_c = {31'd0, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_result_c = {31'd0, (op_a < op_b)};
            ALU_LUI:  alu_result_c = {op_b[15:0], 16'h0000};
            ALU_MFHI: alu_result_c = hi_val_c;
            ALU_MFLO: alu_result_c = lo_val_c;
            default:  alu_result_c = op_a + op_b;
        endcase
    end

    // EXMEM bundle; stalled, flushed or empty slots become bubbles.
    always_comb begin
        exmem_d = '0;
        if (valid && !flush && !stall_c) begin
            exmem_d = {mem_write, mem_read, wb_ctrl, store_data, alu_result_c};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign EXMEM   = exmem_q;
    assign stall   = stall_c;
    assign md_busy = md_busy_c;

endmodule

// File: tb/tb_pipeline_ex_exmem.sv
// tb_pipeline_ex_exmem: directed-vector bench for pipeline_ex_exmem.
//   Expectations follow the multiply/divide option of the build
//   (PIPELINE_MULDIV_EN defined or not).
module tb_pipeline_ex_exmem;

`ifdef PIPELINE_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int unsigned MD_CYC = MD ? 33 : 0;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_MFHI = 4'd12;
    localparam logic [3:0] F_MFLO = 4'd13;

    logic        clk;
    logic        reset;
    logic        valid;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] store_data;
    logic [4:0]  shamt;
    logic [3:0]  alu_fun;
    logic [2:0]  md_op;
    logic [6:0]  wb_ctrl;
    logic        mem_read;
    logic        mem_write;
    logic        stall;
    logic        md_busy;
    logic [72:0] EXMEM;

    int n_vec = 0;
    int n_bad = 0;

    pipeline_ex_exmem dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .flush      (flush),
        .op_a       (op_a),
        .op_b       (op_b),
        .store_data (store_data),
        .shamt      (shamt),
        .alu_fun    (alu_fun),
        .md_op      (md_op),
        .wb_ctrl    (wb_ctrl),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .stall      (stall),
        .md_busy    (md_busy),
        .EXMEM      (EXMEM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [72:0] got, input logic [72:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        valid = 1'b0; flush = 1'b0; op_a = 32'd0; op_b = 32'd0;
        store_data = 32'd0; shamt = 5'd0; alu_fun = F_ADD; md_op = 3'd0;
        wb_ctrl = 7'd0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] fun, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        idle_in();
        valid = 1'b1; alu_fun = fun; op_a = a; op_b = b; shamt = sh;
        @(posedge clk); #1;
        chk(tag, EXMEM, {41'd0, exp});
    endtask

    // Count stalled cycles of the instruction currently presented (bounded).
    task automatic wait_stall(input string tag);
        int n;
        n = 0;
        #1;
        while (stall === 1'b1 && n < 60) begin
            n++;
            @(posedge clk); #1;
        end
        chk(tag, 73'(n), 73'(MD_CYC));
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        idle_in();
        valid = 1'b1; md_op = op; op_a = a; op_b = b;
        @(posedge clk); #1;
        chk({tag, " busy"}, 73'(md_busy), 73'(MD));
        md_op = 3'd0; alu_fun = F_MFLO; op_a = 32'd0; op_b = 32'd0;
        wait_stall({tag, " stall"});
        @(posedge clk); #1;
        chk({tag, " lo"}, EXMEM, {41'd0, (MD ? exp_lo : 32'd0)});
        alu_fun = F_MFHI;
        @(posedge clk); #1;
        chk({tag, " hi"}, EXMEM, {41'd0, (MD ? exp_hi : 32'd0)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        reset = 1'b0;
        valid = 1'b1; alu_fun = F_MFLO;
        #3;
        chk("rst exmem", EXMEM, 73'd0);
        chk("rst busy", 73'(md_busy), 73'd0);
        chk("rst stall", 73'(stall), 73'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        alu_vec("add wrap", 4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000);
        alu_vec("sub",      4'd1,  32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF);
        alu_vec("and",      4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000);
        alu_vec("or",       4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hFFF0_FFF0);
        alu_vec("xor",      4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h0FF0_0FF0);
        alu_vec("nor",      4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h000F_000F);
        alu_vec("sll",      4'd6,  32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000);
        alu_vec("srl",      4'd7,  32'h0,         32'h8000_0000, 5'd4,  32'h0800_0000);
        alu_vec("sra",      4'd8,  32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000);
        alu_vec("slt",      4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001);
        alu_vec("sltu",     4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000);
        alu_vec("lui",      4'd11, 32'h0,         32'h1234_ABCD, 5'd0,  32'hABCD_0000);
        alu_vec("fun15",    4'd15, 32'h0000_0002, 32'h0000_0003, 5'd0,  32'h0000_0005);

        idle_in();
        valid = 1'b1; flush = 1'b1; mem_write = 1'b1; wb_ctrl = 7'h55;
        store_data = 32'hDEAD_BEEF; op_a = 32'h0000_1000; op_b = 32'h0000_0004;
        @(posedge clk); #1;
        chk("sw flushed", EXMEM, 73'd0);
        flush = 1'b0;
        @(posedge clk); #1;
        chk("sw", EXMEM, {1'b1, 1'b0, 7'h55, 32'hDEAD_BEEF, 32'h0000_1004});
        mem_write = 1'b0; mem_read = 1'b1; wb_ctrl = 7'h3A;
        @(posedge clk); #1;
        chk("lw", EXMEM, {1'b0, 1'b1, 7'h3A, 32'hDEAD_BEEF, 32'h0000_1004});
        valid = 1'b0;
        @(posedge clk); #1;
        chk("not valid", EXMEM, 73'd0);

        run_md("mult",     3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32'hFFFF_FFFF);
        run_md("multu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        run_md("div",      3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_md("divu0",    3'd4, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0007);
        run_md("div0 neg", 3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        run_md("div ovf",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);

        // Back-to-back: the second multiply waits for the first to retire.
        idle_in();
        valid = 1'b1; md_op = 3'd1; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk); #1;
        md_op = 3'd2; op_a = 32'd4; op_b = 32'd6;
        wait_stall("b2b stall");
        @(posedge clk); #1;
        md_op = 3'd0; alu_fun = F_MFLO; op_a = 32'd0; op_b = 32'd0;
        wait_stall("b2b mflo stall");
        @(posedge clk); #1;
        chk("b2b lo", EXMEM, {41'd0, (MD ? 32'd24 : 32'd0)});

        idle_in();
        valid = 1'b1; md_op = 3'd5; op_a = 32'h1234_5678;
        @(posedge clk); #1;
        alu_vec("mthi", F_MFHI, 32'd0, 32'd0, 5'd0, (MD ? 32'h1234_5678 : 32'd0));

        // Reset in the middle of a divide.
        idle_in();
        valid = 1'b1; md_op = 3'd3; op_a = 32'd100; op_b = 32'd3;
        @(posedge clk); #1;
        md_op = 3'd0; op_a = 32'd5; op_b = 32'd6;
        repeat (10) @(posedge clk);
        #1;
        chk("pre-rst busy", 73'(md_busy), 73'(MD));
        chk("pre-rst exmem", EXMEM, 73'd11);
        #1 reset = 1'b0;
        #1;
        chk("mid-rst exmem", EXMEM, 73'd0);
        chk("mid-rst busy", 73'(md_busy), 73'd0);
        @(negedge clk) reset = 1'b1;
        alu_vec("post-rst mflo", F_MFLO, 32'd0, 32'd0, 5'd0, 32'd0);
        alu_vec("post-rst mfhi", F_MFHI, 32'd0, 32'd0, 5'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
